// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - instruction fetch FSM with zero-latency memory and small fetch queue
module fetch_controller #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 7,
  parameter int          QDEPTH     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        fetch_fault
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  // Highest pc at which a whole 32-bit word still fits in the memory
  localparam logic [31:0] LAST_PC = 32'((64'd1 << ADDR_WIDTH) - 64'd4);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FAULT} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic            r_fault;
  logic [31:0]     r_pc;
  logic [31:0]     r_q_pc   [QDEPTH];
  logic [31:0]     r_q_data [QDEPTH];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic            w_pop;
  logic            w_in_range;
  logic            w_room;
  logic            w_unused;

  // Low address bits of a redirect target are dropped by design
  assign w_unused   = ^redirect_pc[1:0];

  assign w_in_range  = (r_pc <= LAST_PC);
  assign instr_valid = !rst && (r_count != '0);
  assign w_pop       = instr_valid && instr_ready;
  assign w_room      = (r_count < CW'(QDEPTH)) || w_pop;
  assign imem_addr   = r_pc;
  assign instr_data  = r_q_data[r_rd_ptr];
  assign instr_pc    = r_q_pc[r_rd_ptr];
  assign fetch_fault = r_fault;

  // State register; the fault flag is registered alongside the state it mirrors
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_fault <= (w_next_state == S_FAULT);
    end
  end

  // Next-state logic; a redirect takes priority over fault detection and fetch_en
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (fetch_en) w_next_state = S_FETCH;
      end
      S_FETCH: begin
        if (redirect_valid)   w_next_state = S_FETCH;
        else if (!w_in_range) w_next_state = S_FAULT;
        else if (!fetch_en)   w_next_state = S_IDLE;
      end
      S_FAULT: begin
        if (redirect_valid) w_next_state = fetch_en ? S_FETCH : S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Memory request: only in FETCH with a legal pc and a free (or freeing) queue slot
  always_comb begin
    imem_req = 1'b0;
    if (!rst && (r_state == S_FETCH) && fetch_en && !redirect_valid && w_in_range && w_room)
      imem_req = 1'b1;
  end

  // Program counter: reset, redirect (word aligned), or advance on each accepted request
  always_ff @(posedge clk) begin
    if (rst)                 r_pc <= RESET_PC;
    else if (redirect_valid) r_pc <= {redirect_pc[31:2], 2'b00};
    else if (imem_req)       r_pc <= r_pc + 32'd4;
  end

  // Queue storage is written at the tail on every accepted request
  always_ff @(posedge clk) begin
    if (imem_req) begin
      r_q_pc[r_wr_ptr]   <= r_pc;
      r_q_data[r_wr_ptr] <= imem_data;
    end
  end

  // Queue pointers and occupancy; redirect discards everything including a same-cycle pop
  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (imem_req) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + PW'(1);
      if (imem_req && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !imem_req) r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - randomized bench with queue-based reference model for fetch_controller
module tb_fetch_controller;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          ADDR_WIDTH = 7;
  localparam int          QDEPTH     = 2;
  localparam logic [31:0] LAST       = 32'((1 << ADDR_WIDTH) - 4);

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        fetch_fault;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_controller #(
    .RESET_PC(RESET_PC), .ADDR_WIDTH(ADDR_WIDTH), .QDEPTH(QDEPTH)
  ) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc), .fetch_fault(fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign imem_data = memf(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 fetching, 2 faulted; queue of {pc,data}
  logic [63:0] m_q [$];
  logic [31:0] m_pc;
  int          m_mode;
  bit          m_known = 0;
  bit          e_valid, e_pop, e_req, e_inr;
  logic [63:0] e_head;

  always @(negedge clk) begin
    if (m_known) begin
      e_valid = !rst && (m_q.size() != 0);
      e_pop   = e_valid && instr_ready;
      e_inr   = (m_pc <= LAST);
      e_req   = !rst && (m_mode == 1) && fetch_en && !redirect_valid && e_inr
                && ((m_q.size() < QDEPTH) || e_pop);
      chk("imem_req", 32'(imem_req), 32'(e_req));
      chk("imem_addr", imem_addr, m_pc);
      chk("instr_valid", 32'(instr_valid), 32'(e_valid));
      chk("fetch_fault", 32'(fetch_fault), 32'(m_mode == 2));
      if (e_valid) begin
        e_head = m_q[0];
        chk("instr_pc", instr_pc, e_head[63:32]);
        chk("instr_data", instr_data, e_head[31:0]);
      end
    end
    if (rst) begin
      m_q.delete();
      m_pc    = RESET_PC;
      m_mode  = 0;
      m_known = 1;
    end else if (m_known) begin
      if (redirect_valid) begin
        m_q.delete();
        m_pc = {redirect_pc[31:2], 2'b00};
        if (m_mode != 1) m_mode = fetch_en ? 1 : 0;
      end else begin
        if (e_pop) void'(m_q.pop_front());
        if (e_req) begin
          m_q.push_back({m_pc, memf(m_pc)});
          m_pc = m_pc + 32'd4;
        end
        case (m_mode)
          0: if (fetch_en) m_mode = 1;
          1: if (!e_inr) m_mode = 2; else if (!fetch_en) m_mode = 0;
          default: m_mode = 2;
        endcase
      end
    end
  end

  task automatic step(input bit r, input bit en, input bit rv, input logic [31:0] rpc, input bit rdy);
    @(posedge clk);
    #1;
    rst = r; fetch_en = en; redirect_valid = rv; redirect_pc = rpc; instr_ready = rdy;
    #2;
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_fault", 32'(fetch_fault), 32'h0);
    chk("rst_req", 32'(imem_req), 32'h0);
    // streaming
    step(0, 1, 0, 0, 1);
    chk("idle_req", 32'(imem_req), 32'h0);
    step(0, 1, 0, 0, 1);
    chk("s_req0", 32'(imem_req), 32'h1);
    chk("s_addr0", imem_addr, 32'h0);
    step(0, 1, 0, 0, 1);
    chk("s_addr4", imem_addr, 32'h4);
    chk("s_pc0", instr_pc, 32'h0);
    step(0, 1, 0, 0, 1);
    chk("s_addr8", imem_addr, 32'h8);
    chk("s_pc4", instr_pc, 32'h4);
    // backpressure fills the queue
    step(0, 1, 0, 0, 0);
    chk("bp_req", 32'(imem_req), 32'h1);
    step(0, 1, 0, 0, 0);
    chk("full_req", 32'(imem_req), 32'h0);
    chk("full_pc", instr_pc, 32'h8);
    step(0, 1, 0, 0, 0);
    chk("hold_pc", instr_pc, 32'h8);
    chk("hold_data", instr_data, memf(32'h8));
    step(0, 1, 0, 0, 1);
    chk("swap_req", 32'(imem_req), 32'h1);
    chk("swap_addr", imem_addr, 32'h10);
    step(0, 1, 0, 0, 0);
    chk("swap_head", instr_pc, 32'hC);
    chk("swap_full", 32'(imem_req), 32'h0);
    // redirect with unaligned target
    step(0, 1, 1, 32'h23, 0);
    chk("rd_req", 32'(imem_req), 32'h0);
    step(0, 1, 0, 0, 0);
    chk("rd_valid", 32'(instr_valid), 32'h0);
    chk("rd_addr", imem_addr, 32'h20);
    step(0, 1, 0, 0, 0);
    chk("rd_head", instr_pc, 32'h20);
    // fault at top of memory
    step(0, 1, 1, 32'h7C, 0);
    step(0, 1, 0, 0, 0);
    chk("top_req", 32'(imem_req), 32'h1);
    chk("top_addr", imem_addr, 32'h7C);
    step(0, 1, 0, 0, 0);
    chk("oor_req", 32'(imem_req), 32'h0);
    step(0, 1, 0, 0, 0);
    chk("fault_on", 32'(fetch_fault), 32'h1);
    chk("fault_req", 32'(imem_req), 32'h0);
    chk("fault_head", instr_pc, 32'h7C);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    chk("fault_drained", 32'(instr_valid), 32'h0);
    chk("fault_stay", 32'(fetch_fault), 32'h1);
    step(0, 1, 1, 32'h0, 0);
    step(0, 1, 0, 0, 0);
    chk("fault_off", 32'(fetch_fault), 32'h0);
    chk("refetch_req", 32'(imem_req), 32'h1);
    chk("refetch_addr", imem_addr, 32'h0);
    // reset beats redirect with a full queue
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 1, 1, 32'h40, 0);
    step(0, 0, 0, 0, 0);
    chk("rr_valid", 32'(instr_valid), 32'h0);
    chk("rr_addr", imem_addr, RESET_PC);
    chk("rr_req", 32'(imem_req), 32'h0);
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 19) == 0),
           $urandom_range(0, 32'h9F),
           ($urandom_range(0, 2) != 0));
    end
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch byte address after reset.
REQ-002 Parameter ADDR_WIDTH, default 7, byte-address width of the instruction memory (depth 2**ADDR_WIDTH bytes).
REQ-003 Parameter QDEPTH, default 2, fetch queue entries (power of two, >=2).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 fetch_en  input  1  level; permits new fetches.
REQ-007 redirect_valid  input  1  one-cycle pulse; flush queue and restart fetch at redirect_pc.
REQ-008 redirect_pc  input  32  new fetch byte address; bits [1:0] ignored (treated as 0).
REQ-009 imem_req  output  1  read enable to instruction memory.
REQ-010 imem_addr  output  32  word-aligned byte address to instruction memory; equals internal pc at all times.
REQ-011 imem_data  input  32  instruction returned combinationally, same cycle as imem_req.
REQ-012 instr_valid  output  1  queue head holds a valid instruction.
REQ-013 instr_ready  input  1  consumer accepts head this cycle.
REQ-014 instr_data  output  32  head instruction; instr_pc  output  32  head fetch address.
REQ-015 fetch_fault  output  1  registered; high while in FAULT state.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, FAULT; encoding free.
REQ-017 IDLE->FETCH when fetch_en=1; FETCH->IDLE when fetch_en=0 and no redirect.
REQ-018 In FETCH, pc > 2**ADDR_WIDTH-4 (no full word in range) SHALL move to FAULT at next edge with no imem_req issued for that pc.
REQ-019 FAULT is left only by redirect_valid: to FETCH if fetch_en=1, else IDLE; fetch_en alone does not exit FAULT.
REQ-020 imem_req SHALL be 1 iff state=FETCH, fetch_en=1, redirect_valid=0, pc in range, and (count<QDEPTH or pop this cycle).
REQ-021 When imem_req=1: push {pc, imem_data} into queue tail and pc <= pc+4 at the same edge (fetch latency zero cycles, result visible on instr_* next cycle).
REQ-022 Pop occurs when instr_valid=1 and instr_ready=1; instr_valid = (count!=0); instr_data/instr_pc driven combinationally from head entry.
REQ-023 Simultaneous push and pop SHALL leave count unchanged, including when queue full.
REQ-024 Queue pointers SHALL wrap modulo QDEPTH; count width clog2(QDEPTH+1); count never exceeds QDEPTH nor underflows.
REQ-025 redirect_valid=1 (any state) SHALL: set count and pointers to 0, pc <= {redirect_pc[31:2],2'b00}, suppress imem_req that cycle; a handshake completing in the same cycle counts as consumed; instr_valid=0 on the next cycle.
REQ-026 fetch_en=0 SHALL stop new requests only; queued entries remain and drain normally.
REQ-027 instr_data/instr_pc SHALL hold stable while instr_valid=1 and instr_ready=0.
REQ-028 pc arithmetic is 32-bit unsigned; wrap past 2**32 impossible due to REQ-018.
REQ-029 In FAULT, queued entries preceding the faulting pc SHALL still drain.

Reset
REQ-030 On rst=1 at clock edge: state=IDLE, pc=RESET_PC, count=0, pointers=0, fetch_fault=0.
REQ-031 During and after rst: imem_req=0, instr_valid=0, imem_addr=RESET_PC until first fetch.
REQ-032 rst mid-operation SHALL discard queue contents and override a concurrent redirect_valid.

Verification
REQ-033 Reset, fetch_en=1, instr_ready=1 -> imem_addr 0,4,8,... on consecutive cycles; instr_pc one cycle later, one instruction per cycle.
REQ-034 instr_ready=0, fetch_en=1 -> two pushes (pc 0,4), then imem_req=0, instr_pc=0 held stable; raise ready -> pc 0,4,8 in order, no loss or duplicate.
REQ-035 Queue full, instr_ready=1 for one cycle -> pop and push same cycle, count stays 2, next fetch address 8.
REQ-036 redirect_valid with redirect_pc=32'h0000_0023 while queue holds 2 entries -> next cycle instr_valid=0, imem_addr=32'h20, following head instr_pc=32'h20.
REQ-037 ADDR_WIDTH=7, redirect to 32'h7C -> one fetch at 0x7C, then FAULT, fetch_fault=1, imem_req=0; entry 0x7C still drains; redirect to 0 -> FETCH, fetch_fault=0.
REQ-038 rst asserted with queue full and redirect_valid=1 -> next cycle state IDLE, instr_valid=0, imem_addr=RESET_PC.
